// File: rtl/mips_multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control unit:
//   opcode/funct constants, ALU control codes, FSM state enum, the
//   per-state control word and its decode function.
// Ports: none (package).
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

  // aluop[1]=1 means "decode funct"; 2'b11 is treated the same as 2'b10
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  // Moore control word produced by each state
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  // Per-state control word; unlisted fields and undefined states are all 0
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: bundle between the multicycle control unit and its datapath.
//   master: control unit (consumes op/funct/zero, drives controls)
//   slave : datapath (drives op/funct/zero, consumes controls)
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]     op;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic                iord;
  logic                memwrite;
  logic                irwrite;
  logic                regdst;
  logic                memtoreg;
  logic                regwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [1:0]          pcsrc;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                pcen;
  logic                illegal_op;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal_op, state_dbg
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl_aludec.sv
// Purpose: combinational ALU decoder, aluop + funct -> alucontrol.
// Ports: aluop_i (2), funct_i (6) in; alucontrol_o (3) out.
module aludec
  import mips_ctrl_pkg::*;
(
  input  aluop_t              aluop_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ALUCTL_W-1:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUCTL_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
      ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
      default: begin
        // unknown funct falls back to add; the instruction still writes back
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALUCTL_ADD;
          FUNCT_SUB: alucontrol_o = ALUCTL_SUB;
          FUNCT_AND: alucontrol_o = ALUCTL_AND;
          FUNCT_OR:  alucontrol_o = ALUCTL_OR;
          FUNCT_SLT: alucontrol_o = ALUCTL_SLT;
          default:   alucontrol_o = ALUCTL_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: Moore FSM sequencing the multicycle MIPS datapath (shared memory,
//   shared ALU). Control word is registered alongside the state; reset forces
//   FETCH mux selects with all enables low in the same cycle.
// Ports: clk, reset (sync, active-high); ctrl (master modport) carrying
//   op/funct/zero in and all mux selects, enables, pcen, illegal_op,
//   state_dbg out.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.master ctrl
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_c;

  // Next-state decode
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (ctrl.op == OP_LW)      state_d = MEMRD;
        else if (ctrl.op == OP_SW) state_d = MEMWR;
        else                       state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
    // control word is registered for the state being entered
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= state_ctrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Reset override: FETCH selects, every enable forced low (aborts writes)
  always_comb begin
    ctrl_c = ctrl_q;
    if (reset) begin
      ctrl_c          = state_ctrl(FETCH);
      ctrl_c.memwrite = 1'b0;
      ctrl_c.irwrite  = 1'b0;
      ctrl_c.regwrite = 1'b0;
      ctrl_c.pcwrite  = 1'b0;
      ctrl_c.branch   = 1'b0;
    end
  end

  aludec u_aludec (
    .aluop_i      (ctrl_c.aluop),
    .funct_i      (ctrl.funct),
    .alucontrol_o (ctrl.alucontrol)
  );

  assign ctrl.iord       = ctrl_c.iord;
  assign ctrl.memwrite   = ctrl_c.memwrite;
  assign ctrl.irwrite    = ctrl_c.irwrite;
  assign ctrl.regdst     = ctrl_c.regdst;
  assign ctrl.memtoreg   = ctrl_c.memtoreg;
  assign ctrl.regwrite   = ctrl_c.regwrite;
  assign ctrl.alusrca    = ctrl_c.alusrca;
  assign ctrl.alusrcb    = ctrl_c.alusrcb;
  assign ctrl.pcsrc      = ctrl_c.pcsrc;
  assign ctrl.pcen       = ctrl_c.pcwrite | (ctrl_c.branch & ctrl.zero);
  assign ctrl.illegal_op = (state_q == DECODE) && !op_supported(ctrl.op) && !reset;
  assign ctrl.state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.memwrite !== 1'b0) begin
        errors++; $display("FAIL reset_memwrite[%0d]: got %b want 0", i, bus.memwrite);
      end
      checks++;
      if (bus.irwrite !== 1'b0 || bus.pcen !== 1'b0 || bus.regwrite !== 1'b0) begin
        errors++; $display("FAIL reset_enables[%0d]: irwrite=%b pcen=%b regwrite=%b want 000",
                           i, bus.irwrite, bus.pcen, bus.regwrite);
      end
      checks++;
      if (bus.state_dbg !== 4'd0) begin
        errors++; $display("FAIL reset_state[%0d]: got %0d want 0", i, bus.state_dbg);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      errors++; $display("FAIL release_state: got %0d want 0", bus.state_dbg);
    end
    checks++;
    if (bus.irwrite !== 1'b1 || bus.pcen !== 1'b1) begin
      errors++; $display("FAIL release_fetch: irwrite=%b pcen=%b want 11", bus.irwrite, bus.pcen);
    end
    checks++;
    if (bus.alusrcb !== 2'b01 || bus.alucontrol !== 3'b010 || bus.iord !== 1'b0) begin
      errors++; $display("FAIL release_selects: alusrcb=%b alucontrol=%b iord=%b want 01 010 0",
                         bus.alusrcb, bus.alucontrol, bus.iord);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state_dbg !== exp_s[i]) begin
        errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_dbg, exp_s[i]);
      end
      checks++;
      if (bus.iord !== (i == 3)) begin
        errors++; $display("FAIL lw_iord[%0d]: got %b want %b", i, bus.iord, (i == 3));
      end
      checks++;
      if (bus.regwrite !== (i == 4) || bus.memtoreg !== (i == 4)) begin
        errors++; $display("FAIL lw_wb[%0d]: regwrite=%b memtoreg=%b want %b", i,
                           bus.regwrite, bus.memtoreg, (i == 4));
      end
      if (i == 2) begin
        checks++;
        if (bus.alusrca !== 1'b1 || bus.alusrcb !== 2'b10 || bus.alucontrol !== 3'b010) begin
          errors++; $display("FAIL lw_memadr: alusrca=%b alusrcb=%b alucontrol=%b want 1 10 010",
                             bus.alusrca, bus.alusrcb, bus.alucontrol);
        end
      end
      step();
    end
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      errors++; $display("FAIL lw_end: got %0d want 0", bus.state_dbg);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    int wr_cnt = 0;
    bus.op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.state_dbg !== exp_s[i]) begin
        errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state_dbg, exp_s[i]);
      end
      checks++;
      if (bus.memwrite !== (i == 3) || bus.iord !== (i == 3)) begin
        errors++; $display("FAIL sw_mem[%0d]: memwrite=%b iord=%b want %b", i,
                           bus.memwrite, bus.iord, (i == 3));
      end
      if (bus.memwrite === 1'b1) wr_cnt++;
      step();
    end
    checks++;
    if (wr_cnt != 1) begin
      errors++; $display("FAIL sw_pulses: got %0d want 1", wr_cnt);
    end
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      errors++; $display("FAIL sw_end: got %0d want 0", bus.state_dbg);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [3] = '{6'b100010, 6'b101010, 6'b000000};
    logic [2:0] exp [3] = '{3'b110, 3'b111, 3'b010};
    bus.op = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      bus.funct = fn[k];
      step();
      checks++;
      if (bus.state_dbg !== 4'd1 || bus.alucontrol !== 3'b010 || bus.alusrcb !== 2'b11) begin
        errors++; $display("FAIL rtype_decode[%0d]: state=%0d alucontrol=%b alusrcb=%b want 1 010 11",
                           k, bus.state_dbg, bus.alucontrol, bus.alusrcb);
      end
      step();
      checks++;
      if (bus.state_dbg !== 4'd6 || bus.alucontrol !== exp[k] || bus.alusrcb !== 2'b00 ||
          bus.alusrca !== 1'b1 || bus.regwrite !== 1'b0) begin
        errors++; $display("FAIL rtype_ex[%0d]: state=%0d alucontrol=%b srcb=%b srca=%b rw=%b want 6 %b 00 1 0",
                           k, bus.state_dbg, bus.alucontrol, bus.alusrcb, bus.alusrca,
                           bus.regwrite, exp[k]);
      end
      step();
      checks++;
      if (bus.state_dbg !== 4'd7 || bus.regdst !== 1'b1 || bus.regwrite !== 1'b1 ||
          bus.memtoreg !== 1'b0) begin
        errors++; $display("FAIL rtype_wb[%0d]: state=%0d regdst=%b regwrite=%b memtoreg=%b want 7 1 1 0",
                           k, bus.state_dbg, bus.regdst, bus.regwrite, bus.memtoreg);
      end
      step();
      checks++;
      if (bus.state_dbg !== 4'd0) begin
        errors++; $display("FAIL rtype_end[%0d]: got %0d want 0", k, bus.state_dbg);
      end
    end
    bus.funct = 6'b000000;
  endtask

  task automatic test_beq();
    bus.op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      bus.zero = (k == 0);
      step();
      step();
      checks++;
      if (bus.state_dbg !== 4'd8 || bus.pcsrc !== 2'b01 || bus.alucontrol !== 3'b110) begin
        errors++; $display("FAIL beq_ex[%0d]: state=%0d pcsrc=%b alucontrol=%b want 8 01 110",
                           k, bus.state_dbg, bus.pcsrc, bus.alucontrol);
      end
      checks++;
      if (bus.pcen !== (k == 0)) begin
        errors++; $display("FAIL beq_pcen[%0d]: got %b want %b", k, bus.pcen, (k == 0));
      end
      step();
      checks++;
      if (bus.state_dbg !== 4'd0) begin
        errors++; $display("FAIL beq_end[%0d]: got %0d want 0", k, bus.state_dbg);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_addi_j();
    bus.op = 6'b001000;
    step();
    step();
    checks++;
    if (bus.state_dbg !== 4'd9 || bus.alusrcb !== 2'b10 || bus.regwrite !== 1'b0) begin
      errors++; $display("FAIL addi_ex: state=%0d alusrcb=%b regwrite=%b want 9 10 0",
                         bus.state_dbg, bus.alusrcb, bus.regwrite);
    end
    step();
    checks++;
    if (bus.state_dbg !== 4'd10 || bus.regwrite !== 1'b1 || bus.regdst !== 1'b0) begin
      errors++; $display("FAIL addi_wb: state=%0d regwrite=%b regdst=%b want 10 1 0",
                         bus.state_dbg, bus.regwrite, bus.regdst);
    end
    step();
    bus.op = 6'b000010;
    step();
    step();
    checks++;
    if (bus.state_dbg !== 4'd11 || bus.pcsrc !== 2'b10 || bus.pcen !== 1'b1) begin
      errors++; $display("FAIL j_ex: state=%0d pcsrc=%b pcen=%b want 11 10 1",
                         bus.state_dbg, bus.pcsrc, bus.pcen);
    end
    step();
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      errors++; $display("FAIL j_end: got %0d want 0", bus.state_dbg);
    end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    bus.op = 6'b111111;
    if (bus.illegal_op === 1'b1) pulses++;
    step();
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.illegal_op !== 1'b1) begin
      errors++; $display("FAIL illegal_decode: state=%0d illegal_op=%b want 1 1",
                         bus.state_dbg, bus.illegal_op);
    end
    if (bus.illegal_op === 1'b1) pulses++;
    step();
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_end: state=%0d illegal_op=%b want 0 0",
                         bus.state_dbg, bus.illegal_op);
    end
    if (bus.illegal_op === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL illegal_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    bus.op = 6'b101011;
    step();
    step();
    checks++;
    if (bus.state_dbg !== 4'd2) begin
      errors++; $display("FAIL abort_memadr: got %0d want 2", bus.state_dbg);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.memwrite !== 1'b0 || bus.regwrite !== 1'b0 || bus.pcen !== 1'b0) begin
      errors++; $display("FAIL abort_enables: memwrite=%b regwrite=%b pcen=%b want 000",
                         bus.memwrite, bus.regwrite, bus.pcen);
    end
    step();
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.memwrite !== 1'b0) begin
      errors++; $display("FAIL abort_state: state=%0d memwrite=%b want 0 0",
                         bus.state_dbg, bus.memwrite);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.irwrite !== 1'b1 || bus.memwrite !== 1'b0 || bus.state_dbg !== 4'd0) begin
      errors++; $display("FAIL abort_release: irwrite=%b memwrite=%b state=%0d want 1 0 0",
                         bus.irwrite, bus.memwrite, bus.state_dbg);
    end
    step();
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.memwrite !== 1'b0) begin
      errors++; $display("FAIL abort_restart: state=%0d memwrite=%b want 1 0",
                         bus.state_dbg, bus.memwrite);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_illegal();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
